// File: rtl/in_fm_tile_loader_pkg.sv
// Shared types and helpers for the input-feature-map tile loader.
package in_fm_tile_loader_pkg;

  // Each issue-pipeline stage carries {legal, valid}.
  localparam int unsigned PIPE_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  // Runtime tile size clamped to 1..vmax (zero is treated as one).
  function automatic logic [63:0] clamp_size(input logic [63:0] v, input logic [63:0] vmax);
    logic [63:0] res;
    if (v == 64'd0) begin
      res = 64'd1;
    end else if (v > vmax) begin
      res = vmax;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/in_fm_tile_loader_nest3_counter.sv
// Three-level nested counter with runtime bounds; c0 is the innermost loop.
module in_fm_tile_loader_nest3_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] n0_max_i,
  input  logic [W-1:0] n1_max_i,
  input  logic [W-1:0] n2_max_i,
  output logic [W-1:0] c0_o,
  output logic [W-1:0] c1_o,
  output logic [W-1:0] c2_o,
  output logic         last_o
);

  logic [W-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic         last0, last1, last2;

  assign last0  = (c0_q == n0_max_i);
  assign last1  = (c1_q == n1_max_i);
  assign last2  = (c2_q == n2_max_i);
  assign last_o = last0 && last1 && last2;
  assign c0_o   = c0_q;
  assign c1_o   = c1_q;
  assign c2_o   = c2_q;

  // Ripple-carry advance across the three loop levels.
  always_comb begin
    c0_d = c0_q;
    c1_d = c1_q;
    c2_d = c2_q;
    if (clr_i) begin
      c0_d = '0;
      c1_d = '0;
      c2_d = '0;
    end else if (en_i) begin
      if (!last0) begin
        c0_d = c0_q + W'(1);
      end else begin
        c0_d = '0;
        if (!last1) begin
          c1_d = c1_q + W'(1);
        end else begin
          c1_d = '0;
          c2_d = last2 ? '0 : c2_q + W'(1);
        end
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c0_q <= '0;
      c1_q <= '0;
      c2_q <= '0;
    end else begin
      c0_q <= c0_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
    end
  end

endmodule

// File: rtl/in_fm_tile_loader.sv
// Streams one in_fm[M][R][C] tile from RAM into the in_fm FIFO, zero-filling
// out-of-bounds elements. Optional stall counter: IN_FM_TILE_LOADER_PERF_EN.
module in_fm_tile_loader
  import in_fm_tile_loader_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned M      = 32,
  parameter int unsigned R      = 64,
  parameter int unsigned C      = 32,
  parameter int unsigned Tm     = 8,
  parameter int unsigned Tr     = 16,
  parameter int unsigned Tc     = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] tile_base_m,
  input  logic [AW-1:0] tile_base_row,
  input  logic [AW-1:0] tile_base_col,
  input  logic [AW-1:0] tile_m,
  input  logic [AW-1:0] tile_r,
  input  logic [AW-1:0] tile_c,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] data_from_ram,
  output logic          fifo_push,
  output logic [DW-1:0] data_to_fifo,
  input  logic          fifo_almost_full
`ifdef IN_FM_TILE_LOADER_PERF_EN
  ,
  output logic [AW-1:0] stall_cycles
`endif
);

  state_t state_q, state_d;
  logic [AW-1:0] base_m_q, base_r_q, base_c_q;
  logic [AW-1:0] max_m_q, max_r_q, max_c_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] tm, tr, tc;
  logic          last_elem;
  logic          accept, issue, legal, issue_legal;
  logic [AW:0]   sum_m, sum_r, sum_c;
  logic [AW-1:0] addr_calc;
  logic [RD_LAT-1:0][PIPE_W-1:0] pipe_q, pipe_d;

  assign accept = (state_q == StIdle) && start;
  assign issue  = (state_q == StIssue) && !fifo_almost_full;

  in_fm_tile_loader_nest3_counter #(
    .W(AW)
  ) u_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (accept),
    .en_i    (issue),
    .n0_max_i(max_c_q),
    .n1_max_i(max_r_q),
    .n2_max_i(max_m_q),
    .c0_o    (tc),
    .c1_o    (tr),
    .c2_o    (tm),
    .last_o  (last_elem)
  );

  // One extra bit on the sums so a base near the top of AW cannot wrap into range.
  assign sum_m       = {1'b0, base_m_q} + {1'b0, tm};
  assign sum_r       = {1'b0, base_r_q} + {1'b0, tr};
  assign sum_c       = {1'b0, base_c_q} + {1'b0, tc};
  assign legal       = (sum_m < (AW+1)'(M)) && (sum_r < (AW+1)'(R)) && (sum_c < (AW+1)'(C));
  assign addr_calc   = (sum_m[AW-1:0] * AW'(R) + sum_r[AW-1:0]) * AW'(C) + sum_c[AW-1:0];
  assign issue_legal = issue && legal;

  // Reads go out in the issue cycle; illegal elements leave the address bus untouched.
  assign ram_rd_en = issue_legal;
  assign ram_addr  = issue_legal ? addr_calc : addr_q;

  assign fifo_push    = pipe_q[RD_LAT-1][0];
  assign data_to_fifo = pipe_q[RD_LAT-1][1] ? data_from_ram : '0;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  // Issue pipeline: stage RD_LAT-1 lines up with the returning read data.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {issue_legal, issue};
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Transfer sequencing; DRAIN leaves once the last push is on its final stage.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (issue && last_elem) state_d = StDrain;
      StDrain: if (pipe_d == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, latched tile configuration, last legal address and pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      base_m_q <= '0;
      base_r_q <= '0;
      base_c_q <= '0;
      max_m_q  <= '0;
      max_r_q  <= '0;
      max_c_q  <= '0;
      addr_q   <= '0;
      pipe_q   <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      if (issue_legal) addr_q <= addr_calc;
      if (accept) begin
        base_m_q <= tile_base_m;
        base_r_q <= tile_base_row;
        base_c_q <= tile_base_col;
        max_m_q  <= AW'(clamp_size(64'(tile_m), 64'(Tm)) - 64'd1);
        max_r_q  <= AW'(clamp_size(64'(tile_r), 64'(Tr)) - 64'd1);
        max_c_q  <= AW'(clamp_size(64'(tile_c), 64'(Tc)) - 64'd1);
      end
    end
  end

`ifdef IN_FM_TILE_LOADER_PERF_EN
  logic [AW-1:0] stall_q;

  assign stall_cycles = stall_q;

  // Saturating count of ISSUE cycles held off by the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == StIssue) && fifo_almost_full && (stall_q != '1)) begin
      stall_q <= stall_q + AW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_in_fm_tile_loader.sv
// Self-checking bench for in_fm_tile_loader (RD_LAT=2 main instance, RD_LAT=4 second).
module tb_in_fm_tile_loader;

  localparam int unsigned M = 32, R = 64, C = 32, TM = 8, TR = 16, TC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Instance A (RD_LAT=2)
  logic        start, af, busy, done, rd_en, push;
  logic [31:0] tbm, tbr, tbc, ttm, ttr, ttc, addr, dfr, dtf;
  // Instance B (RD_LAT=4)
  logic        start_b, af_b, busy_b, done_b, rd_en_b, push_b;
  logic [31:0] tbm_b, tbr_b, tbc_b, ttm_b, ttr_b, ttc_b, addr_b, dfr_b, dtf_b;
`ifdef IN_FM_TILE_LOADER_PERF_EN
  logic [31:0] stall_a, stall_b;
`endif

  in_fm_tile_loader #(.RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .tile_base_m(tbm), .tile_base_row(tbr), .tile_base_col(tbc),
    .tile_m(ttm), .tile_r(ttr), .tile_c(ttc),
    .ram_rd_en(rd_en), .ram_addr(addr), .data_from_ram(dfr),
    .fifo_push(push), .data_to_fifo(dtf), .fifo_almost_full(af)
`ifdef IN_FM_TILE_LOADER_PERF_EN
    , .stall_cycles(stall_a)
`endif
  );

  in_fm_tile_loader #(.RD_LAT(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .tile_base_m(tbm_b), .tile_base_row(tbr_b), .tile_base_col(tbc_b),
    .tile_m(ttm_b), .tile_r(ttr_b), .tile_c(ttc_b),
    .ram_rd_en(rd_en_b), .ram_addr(addr_b), .data_from_ram(dfr_b),
    .fifo_push(push_b), .data_to_fifo(dtf_b), .fifo_almost_full(af_b)
`ifdef IN_FM_TILE_LOADER_PERF_EN
    , .stall_cycles(stall_b)
`endif
  );

  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int eff(input int v, input int t);
    return (v == 0) ? 1 : ((v > t) ? t : v);
  endfunction

  // RAM models: data for the address seen RD_LAT cycles earlier.
  logic [31:0] rp_a [2];
  logic [31:0] rp_b [4];
  always @(posedge clk) begin
    rp_a[0] <= addr;
    rp_a[1] <= rp_a[0];
    rp_b[0] <= addr_b;
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
    rp_b[3] <= rp_b[2];
  end
  assign dfr   = ram_fn(rp_a[1]);
  assign dfr_b = ram_fn(rp_b[3]);

  // Monitors
  logic [31:0] obs_rd [$];
  logic [31:0] obs_data [$];
  int          done_cyc [$];
  bit          af_hist [0:99999];
  int          af_viol = 0;
  logic [31:0] b_rd [$];
  int          b_rd_cyc [$];
  logic [31:0] b_data [$];
  int          b_push_cyc [$];
  int          b_done [$];

  always @(negedge clk) begin
    if (cyc < 100000) af_hist[cyc] <= af;
    if (rd_en) obs_rd.push_back(addr);
    if (push) begin
      obs_data.push_back(dtf);
      if (cyc >= 2 && cyc < 100002 && af_hist[cyc-2]) af_viol <= af_viol + 1;
    end
    if (done) done_cyc.push_back(cyc);
    if (rd_en_b) begin
      b_rd.push_back(addr_b);
      b_rd_cyc.push_back(cyc);
    end
    if (push_b) begin
      b_data.push_back(dtf_b);
      b_push_cyc.push_back(cyc);
    end
    if (done_b) b_done.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int last_r0;

  // One transfer on instance A checked against a loop-nest reference.
  // mode: 0 no stall, 1 almost-full toggling every 3 cycles, 2 random.
  task automatic xfer(input int bm, input int br, input int bc, input int sm, input int sr,
                      input int sc, input int mode, input bit poke);
    int em, er, ec, n, st, d0, r0, v0, dn0, dcyc;
    bit ok, lg;
    longint a;
    logic [31:0] exp_d [$];
    logic [31:0] exp_a [$];
    em = eff(sm, TM);
    er = eff(sr, TR);
    ec = eff(sc, TC);
    n  = em * er * ec;
    for (int m = 0; m < em; m++)
      for (int r = 0; r < er; r++)
        for (int c = 0; c < ec; c++) begin
          lg = (bm + m < M) && (br + r < R) && (bc + c < C);
          a  = (longint'(bm + m) * R + (br + r)) * C + (bc + c);
          if (lg) begin
            exp_a.push_back(a[31:0]);
            exp_d.push_back(ram_fn(a[31:0]));
          end else begin
            exp_d.push_back(32'd0);
          end
        end
    d0 = obs_data.size(); r0 = obs_rd.size(); v0 = af_viol; dn0 = done_cyc.size();
    last_r0 = r0;
    @(posedge clk); #1;
    tbm = bm; tbr = br; tbc = bc; ttm = sm; ttr = sr; ttc = sc;
    start = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    tbm = $urandom; tbr = $urandom; tbc = $urandom; ttm = $urandom; ttr = $urandom; ttc = $urandom;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    ok = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      case (mode)
        1:       af = ((cyc / 3) % 2) == 1;
        2:       af = ($urandom_range(0, 2) == 0);
        default: af = 1'b0;
      endcase
      if (poke) start = (k == 4);
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_seen", {63'd0, ok}, 64'd1);
    dcyc = cyc;
    start = poke;  // lands in the DONE cycle when poking
    @(posedge clk); #1;
    start = 1'b0;
    af = 1'b0;
    check("busy_after_done", {63'd0, busy}, 64'd0);
    if (mode == 0) check("done_latency", 64'(dcyc - st), 64'(n + 3));
    repeat (15) @(posedge clk);
    #1;
    check("push_count", 64'(obs_data.size() - d0), 64'(n));
    for (int i = 0; i < n && d0 + i < obs_data.size(); i++)
      check($sformatf("push_data[%0d]", i), 64'(obs_data[d0+i]), 64'(exp_d[i]));
    check("rd_count", 64'(obs_rd.size() - r0), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && r0 + i < obs_rd.size(); i++)
      check($sformatf("rd_addr[%0d]", i), 64'(obs_rd[r0+i]), 64'(exp_a[i]));
    check("af_safety", 64'(af_viol - v0), 64'd0);
    check("done_count", 64'(done_cyc.size() - dn0), 64'd1);
  endtask

  // Transfer of sizes (1,1,3) at origin on instance B, optionally with a 5-cycle stall.
  task automatic xfer_b(input bit stall);
    int r0, p0, dn0, st, dcyc;
    bit ok;
    r0 = b_rd.size(); p0 = b_data.size(); dn0 = b_done.size();
    @(posedge clk); #1;
    tbm_b = 0; tbr_b = 0; tbc_b = 0; ttm_b = 1; ttr_b = 1; ttc_b = 3;
    start_b = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    start_b = 1'b0;
    if (stall) begin
      af_b = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      af_b = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_b) begin
        ok = 1'b1;
        break;
      end
    end
    check("b_done_seen", {63'd0, ok}, 64'd1);
    dcyc = cyc;
    if (!stall) check("b_done_latency", 64'(dcyc - st), 64'd8);
    repeat (8) @(posedge clk);
    #1;
    check("b_rd_count", 64'(b_rd.size() - r0), 64'd3);
    check("b_push_count", 64'(b_data.size() - p0), 64'd3);
    for (int i = 0; i < 3 && r0 + i < b_rd.size() && p0 + i < b_data.size(); i++) begin
      check($sformatf("b_rd_addr[%0d]", i), 64'(b_rd[r0+i]), 64'(i));
      check($sformatf("b_data[%0d]", i), 64'(b_data[p0+i]), 64'(ram_fn(i)));
      check($sformatf("b_push_delay[%0d]", i), 64'(b_push_cyc[p0+i] - b_rd_cyc[r0+i]), 64'd4);
    end
    check("b_done_count", 64'(b_done.size() - dn0), 64'd1);
`ifdef IN_FM_TILE_LOADER_PERF_EN
    check("b_stall_cycles", 64'(stall_b), stall ? 64'd5 : 64'd0);
`endif
  endtask

  logic [31:0] lit1 [8];
  int dn0, p0;
  int bm, br, bc;

  initial begin
    rst = 1'b0;
    start = 1'b0; af = 1'b0; tbm = '0; tbr = '0; tbc = '0; ttm = '0; ttr = '0; ttc = '0;
    start_b = 1'b0; af_b = 1'b0; tbm_b = '0; tbr_b = '0; tbc_b = '0;
    ttm_b = '0; ttr_b = '0; ttc_b = '0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_rd_en", {63'd0, rd_en}, 64'd0);
    check("rst_push", {63'd0, push}, 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_data", 64'(dtf), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Small all-legal tile with known addresses.
    xfer(0, 0, 0, 2, 2, 2, 0, 1'b0);
    lit1 = '{32'd0, 32'd1, 32'd32, 32'd33, 32'd2048, 32'd2049, 32'd2080, 32'd2081};
    for (int i = 0; i < 8 && last_r0 + i < obs_rd.size(); i++)
      check($sformatf("t1_addr[%0d]", i), 64'(obs_rd[last_r0+i]), 64'(lit1[i]));
`ifdef IN_FM_TILE_LOADER_PERF_EN
    check("a_stall_zero", 64'(stall_a), 64'd0);
`endif

    // Column edge: two real reads then two zero fills.
    xfer(0, 0, 30, 1, 1, 4, 0, 1'b0);

    // Full-size tile under periodic back-pressure.
    xfer(0, 0, 0, 8, 16, 8, 1, 1'b0);

    // Start pulses during busy and in the DONE cycle.
    xfer(1, 2, 3, 2, 3, 2, 0, 1'b1);

    // Reset in the middle of a transfer.
    dn0 = done_cyc.size();
    @(posedge clk); #1;
    tbm = 0; tbr = 0; tbc = 0; ttm = 8; ttr = 16; ttc = 8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_rd_en", {63'd0, rd_en}, 64'd0);
    check("abort_push", {63'd0, push}, 64'd0);
    check("abort_addr", 64'(addr), 64'd0);
    check("abort_data", 64'(dtf), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    p0 = obs_data.size();
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cyc.size() - dn0), 64'd0);
    check("abort_no_push", 64'(obs_data.size() - p0), 64'd0);
    check("abort_idle", {63'd0, busy}, 64'd0);
    xfer(3, 5, 28, 2, 3, 6, 0, 1'b0);

    // Clamped sizes: zero and oversize requests.
    xfer(30, 62, 0, 0, 20, 9, 0, 1'b0);

    // Randomized tiles near the array edges with random back-pressure.
    for (int i = 0; i < 6; i++) begin
      bm = $urandom_range(M - 6, M + 1);
      br = $urandom_range(R - 20, R + 1);
      bc = $urandom_range(C - 10, C + 1);
      xfer(bm, br, bc, $urandom_range(0, TM + 2), $urandom_range(0, TR + 2),
           $urandom_range(0, TC + 2), 2, i[0]);
    end

    // Longer read latency instance.
    xfer_b(1'b0);
    xfer_b(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/in_fm_tile_loader.md
Name: in_fm_tile_loader

Overview:
- Next-generation loader that streams one input-feature-map tile from on-chip RAM into the in_fm FIFO.
- In-memory layout is in_fm[M][R][C], row major; tile dimensions are set at run time per transfer, up to the Tm/Tr/Tc maxima.
- Out-of-bounds elements are zero-filled without issuing a RAM read; read latency is a parameter; FIFO overflow is impossible by construction.
- Sits between the feature-map RAM and the convolution core's input FIFO, under control of the tile scheduler.

Parameters:
AW, 32, address and counter width
DW, 32, data width
M, 32, total input channels
R, 64, total rows
C, 32, total columns
Tm, 8, maximum tile channels
Tr, 16, maximum tile rows
Tc, 8, maximum tile columns
RD_LAT, 2, RAM read latency in cycles (legal range 1..4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse that launches a transfer
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last word has been pushed
tile_base_m  in  AW  tile origin, channel
tile_base_row  in  AW  tile origin, row
tile_base_col  in  AW  tile origin, column
tile_m  in  AW  tile channels for this transfer (1..Tm)
tile_r  in  AW  tile rows for this transfer (1..Tr)
tile_c  in  AW  tile columns for this transfer (1..Tc)
ram_rd_en  out  1  RAM read strobe
ram_addr  out  AW  RAM word address
data_from_ram  in  DW  read data, valid RD_LAT cycles after ram_rd_en
fifo_push  out  1  FIFO write strobe
data_to_fifo  out  DW  FIFO write data
fifo_almost_full  in  1  FIFO almost-full flag; FIFO guarantees at least RD_LAT+1 free entries while this is low

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy, done, ram_rd_en, fifo_push = 0; ram_addr and data_to_fifo = 0; all counters and pipelines cleared.
- Reset asserted mid-transfer aborts the transfer with no done pulse.
- Tile configuration (bases and sizes) is latched on the accepted start. Inputs may change freely afterwards.
- FSM states:
  - IDLE: start -> ISSUE. start is ignored in every other state.
  - ISSUE: one element is issued per cycle when fifo_almost_full=0. Column is the innermost loop, then row, then channel. The cycle that issues the last element (tm=tile_m-1, tr=tile_r-1, tc=tile_c-1) -> DRAIN.
  - DRAIN: wait until the issue pipeline is empty -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE. A start seen in this cycle is ignored.
- Element legality: (base_m+tm<M) && (base_row+tr<R) && (base_col+tc<C), evaluated with AW+1-bit sums so there is no wrap.
- Legal element:
  - ram_rd_en=1.
  - ram_addr = ((base_m+tm)*R + (base_row+tr))*C + (base_col+tc), truncated to AW bits.
- Illegal element: ram_rd_en=0 and ram_addr holds its previous value.
- Every issued element, legal or not, produces exactly one fifo_push exactly RD_LAT cycles after issue.
  - data_to_fifo = data_from_ram for legal elements, 0 for illegal ones.
  - Push order equals issue order.
- Stall: fifo_almost_full=1 freezes the counters; in-flight pushes still complete.
- Sizes are clamped: tile_m=0 is treated as 1 and tile_m>Tm as Tm; tile_r and tile_c likewise.
- Total pushes per transfer = tile_m*tile_r*tile_c.
- Latency with no stall: done is asserted tile_m*tile_r*tile_c + RD_LAT + 1 cycles after start.

Optional Feature:
- Macro: IN_FM_TILE_LOADER_PERF_EN.
- Defined:
  - Extra output port stall_cycles [AW-1:0].
  - Counts the cycles spent in ISSUE with fifo_almost_full=1.
  - Cleared on an accepted start, holds its value after done, saturates at all-ones.
- Undefined: no port and no counter logic.

Decomposition:
- Package in_fm_tile_loader_pkg holds:
  - FSM state typedef (IDLE, ISSUE, DRAIN, DONE);
  - a clamp function for the tile sizes;
  - localparam PIPE_W = 2 (legal bit plus valid bit per pipeline stage).
- One sub-module: the existing nest3_counter, made runtime-bound, with n0/n1/n2 max values taken from ports.
- Issue pipeline (RD_LAT-deep shift of valid/legal bits) stays inline.

Test Plan:
1. M=32, R=64, C=32, bases (0,0,0), sizes (2,2,2), fifo never almost full -> 8 pushes; addresses 0,1,32,33,2048,2049,2080,2081; done 11 cycles after start.
2. base_col=30, tile_c=4, tile_r=1, tile_m=1 -> 4 pushes: data from addresses 30 and 31, then two zeros; ram_rd_en high for only 2 cycles.
3. Toggle fifo_almost_full every 3 cycles during sizes (8,16,8) -> exactly 1024 pushes; no push while the FIFO model is full; order checked against the reference scoreboard.
4. Pulse start again during busy and in the DONE cycle -> ignored; exactly one done pulse; push count unchanged.
5. Assert rst low mid-transfer -> all outputs 0 asynchronously; no done; a fresh start afterwards completes normally.
6. RD_LAT=4, sizes (1,1,3) -> pushes 4 cycles after each ram_rd_en; with PERF_EN defined, a 5-cycle almost-full window gives stall_cycles=5.
